// File: rtl/acc_exec_unit.sv
// Accumulator execution unit: accepts one ALU command at a time, sequences the external
// ALU through EXEC (plus MUL2 for multiplies) and writes the result back into acc.
module acc_exec_unit #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acc,
    output logic             z_flag,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL2 = 2'd2,
        RET  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   handshake;
    logic   acc_we;
    logic   done_next;
    logic   err_next;
    logic   illegal_op;

    // Ready is gated by reset so nothing can be accepted while rstN is low.
    assign cmd_ready  = (state == IDLE) && rstN;
    assign handshake  = cmd_valid && cmd_ready;
    assign illegal_op = (alu_sel[2:1] == 2'b11);
    assign alu_a      = acc;
    assign z_flag     = (acc == '0);

    // Next-state and write-enable decode; done/err are registered so they line up with RET.
    always_comb begin
        state_next = state;
        acc_we     = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (alu_sel == OP_MUL) begin
                    state_next = MUL2;
                end else begin
                    state_next = RET;
                    done_next  = 1'b1;
                    err_next   = illegal_op;
                    acc_we     = !illegal_op;
                end
            end
            MUL2: begin
                acc_we     = 1'b1;
                state_next = RET;
                done_next  = 1'b1;
            end
            RET: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            err   <= err_next;
        end
    end

    // Operand capture happens only on a handshake; otherwise the ALU inputs hold.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            alu_b   <= '0;
            alu_sel <= 3'd0;
        end else if (handshake) begin
            alu_b   <= cmd_data;
            alu_sel <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc <= '0;
        end else if (acc_we) begin
            acc <= alu_result;
        end
    end

endmodule
